// File: rtl/csr_hpm.sv
// csr_hpm: mcycle/minstret/mhpmcounter CSR bank with event select,
// counter inhibit and sticky overflow interrupt.
module csr_hpm #(
  parameter int NUM_COUNTERS  = 4,
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_EVENTS    = 16
) (
  input  logic                  clk_core,
  input  logic                  reset_n,
  input  logic [11:0]           csr_addr,
  input  logic [1:0]            csr_write,
  input  logic [31:0]           csr_din,
  output logic [31:0]           csr_dout,
  output logic                  csr_hit,
  output logic                  csr_error,
  input  logic                  inst_retire,
  input  logic [NUM_EVENTS-1:0] hpm_events,
  output logic                  hpm_irq
);
  localparam int NC = NUM_COUNTERS;
  localparam int W  = COUNTER_WIDTH;
  localparam int HW = W - 32;

  logic [W-1:0]  mcycle_q, mcycle_d;
  logic [W-1:0]  minstret_q, minstret_d;
  logic [W-1:0]  hpm_q [NC];
  logic [W-1:0]  hpm_d [NC];
  logic          inh_cy_q, inh_cy_d;
  logic          inh_ir_q, inh_ir_d;
  logic [NC-1:0] inh_hpm_q, inh_hpm_d;
  logic [NC-1:0] of_q, of_d;
  logic [NC-1:0] ovfie_q, ovfie_d;
  logic [7:0]    evsel_q [NC];
  logic [7:0]    evsel_d [NC];
  logic          irq_q, irq_d;

  logic          cnt_space, evt_space;
  logic          shadow, hi, cnt_impl;
  logic [4:0]    idx;
  logic [W-1:0]  cnt_sel;
  logic [31:0]   inh_rd;
  logic [31:0]   rdata;
  logic          hit;
  logic [31:0]   wdata;
  logic          we, we_c;
  logic [255:0]  ev_ext;
  logic [NC-1:0] hpm_inc, hpm_we, hpm_wrap, ev_we;

  // Write wins over increment; high-half writes drop bits above W.
  function automatic logic [W-1:0] cnt_next(
    input logic [W-1:0] cur,
    input logic         wr_lo,
    input logic         wr_hi,
    input logic [31:0]  wd,
    input logic         inc
  );
    logic [W-1:0] n;
    n = cur;
    if (wr_lo)
      n[31:0] = wd;
    else if (wr_hi)
      n[W-1:32] = wd[HW-1:0];
    else if (inc)
      n = cur + W'(1);
    return n;
  endfunction

  always_comb begin
    idx       = csr_addr[4:0];
    hi        = csr_addr[7];
    shadow    = (csr_addr[11:10] == 2'b11);
    cnt_space = ((csr_addr[11:8] == 4'hB)
              || (csr_addr[11:8] == 4'hC))
              && (csr_addr[6:5] == 2'b00);
    evt_space = (csr_addr[11:5] == 7'b0011001);
    cnt_impl  = (idx == 5'd0) || (idx == 5'd2)
              || ((idx >= 5'd3) && (int'(idx) < 3 + NC));
  end

  always_comb begin
    inh_rd    = '0;
    inh_rd[0] = inh_cy_q;
    inh_rd[2] = inh_ir_q;
    for (int i = 0; i < NC; i++)
      inh_rd[i+3] = inh_hpm_q[i];
  end

  always_comb begin
    cnt_sel = '0;
    if (idx == 5'd0) cnt_sel = mcycle_q;
    if (idx == 5'd2) cnt_sel = minstret_q;
    for (int i = 0; i < NC; i++)
      if (idx == 5'(i + 3)) cnt_sel = hpm_q[i];
  end

  always_comb begin
    hit   = 1'b0;
    rdata = '0;
    if (cnt_space && cnt_impl) begin
      hit   = 1'b1;
      rdata = hi ? 32'(cnt_sel[W-1:32]) : cnt_sel[31:0];
    end else if (evt_space) begin
      if (idx == 5'd0) begin
        hit   = 1'b1;
        rdata = inh_rd;
      end
      for (int i = 0; i < NC; i++)
        if (idx == 5'(i + 3)) begin
          hit   = 1'b1;
          rdata = {of_q[i], ovfie_q[i], 22'b0, evsel_q[i]};
        end
    end
  end

  always_comb begin
    unique case (csr_write)
      2'b10:   wdata = rdata | csr_din;
      2'b11:   wdata = rdata & ~csr_din;
      default: wdata = csr_din;
    endcase
  end

  assign we        = (csr_write != 2'b00) && hit && !shadow;
  assign we_c      = we && cnt_space;
  assign csr_error = (csr_write != 2'b00) && hit && shadow;
  assign csr_dout  = rdata;
  assign csr_hit   = hit;
  assign hpm_irq   = irq_q;

  always_comb begin
    ev_ext = '0;
    ev_ext[NUM_EVENTS-1:0] = hpm_events;
    // bit 0 means "no event"
    ev_ext[0] = 1'b0;

    mcycle_d = cnt_next(mcycle_q,
                        we_c && (idx == 5'd0) && !hi,
                        we_c && (idx == 5'd0) && hi,
                        wdata, !inh_cy_q);
    minstret_d = cnt_next(minstret_q,
                          we_c && (idx == 5'd2) && !hi,
                          we_c && (idx == 5'd2) && hi,
                          wdata, inst_retire && !inh_ir_q);

    hpm_inc  = '0;
    hpm_we   = '0;
    hpm_wrap = '0;
    ev_we    = '0;
    for (int i = 0; i < NC; i++) begin
      hpm_inc[i]  = ev_ext[evsel_q[i]] && !inh_hpm_q[i];
      hpm_we[i]   = we_c && (idx == 5'(i + 3));
      hpm_wrap[i] = hpm_inc[i] && !hpm_we[i] && (&hpm_q[i]);
      ev_we[i]    = we && evt_space && (idx == 5'(i + 3));
      hpm_d[i]    = cnt_next(hpm_q[i],
                             hpm_we[i] && !hi,
                             hpm_we[i] && hi,
                             wdata, hpm_inc[i]);
      of_d[i]     = (ev_we[i] ? wdata[31] : of_q[i]) | hpm_wrap[i];
      ovfie_d[i]  = ev_we[i] ? wdata[30] : ovfie_q[i];
      evsel_d[i]  = ev_we[i] ? wdata[7:0] : evsel_q[i];
    end

    inh_cy_d  = inh_cy_q;
    inh_ir_d  = inh_ir_q;
    inh_hpm_d = inh_hpm_q;
    if (we && evt_space && (idx == 5'd0)) begin
      inh_cy_d  = wdata[0];
      inh_ir_d  = wdata[2];
      inh_hpm_d = wdata[NC+2:3];
    end

    irq_d = |(of_q & ovfie_q);
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
      inh_cy_q   <= 1'b0;
      inh_ir_q   <= 1'b0;
      inh_hpm_q  <= '0;
      of_q       <= '0;
      ovfie_q    <= '0;
      irq_q      <= 1'b0;
      for (int i = 0; i < NC; i++) begin
        hpm_q[i]   <= '0;
        evsel_q[i] <= '0;
      end
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      inh_cy_q   <= inh_cy_d;
      inh_ir_q   <= inh_ir_d;
      inh_hpm_q  <= inh_hpm_d;
      of_q       <= of_d;
      ovfie_q    <= ovfie_d;
      irq_q      <= irq_d;
      for (int i = 0; i < NC; i++) begin
        hpm_q[i]   <= hpm_d[i];
        evsel_q[i] <= evsel_d[i];
      end
    end
  end

endmodule

// File: tb/tb_csr_hpm.sv
// tb_csr_hpm: scoreboard bench for csr_hpm (4 counters,
// 40-bit width, 16 events).
module tb_csr_hpm;
  localparam int NE = 16;

  logic          clk_core;
  logic          reset_n;
  logic [11:0]   csr_addr;
  logic [1:0]    csr_write;
  logic [31:0]   csr_din;
  logic [31:0]   csr_dout;
  logic          csr_hit;
  logic          csr_error;
  logic          inst_retire;
  logic [NE-1:0] hpm_events;
  logic          hpm_irq;

  csr_hpm #(
    .NUM_COUNTERS (4),
    .COUNTER_WIDTH(40),
    .NUM_EVENTS   (NE)
  ) dut (
    .clk_core   (clk_core),
    .reset_n    (reset_n),
    .csr_addr   (csr_addr),
    .csr_write  (csr_write),
    .csr_din    (csr_din),
    .csr_dout   (csr_dout),
    .csr_hit    (csr_hit),
    .csr_error  (csr_error),
    .inst_retire(inst_retire),
    .hpm_events (hpm_events),
    .hpm_irq    (hpm_irq)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial begin
    clk_core = 1'b0;
    forever #5 clk_core = ~clk_core;
  end

  initial begin
    #200000;
    $display("FAIL timeout n_tests=%0d", n_tests);
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic rd(input string tag,
                    input logic [11:0] a,
                    input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sbq.push_back(x);
    csr_addr = a;
    #1;
    x = sbq.pop_front();
    check(x.tag, csr_dout, x.exp);
  endtask

  task automatic rd_miss(input string tag,
                         input logic [11:0] a);
    exp_t x;
    x.tag = tag;
    x.exp = 32'h0;
    sbq.push_back(x);
    csr_addr = a;
    #1;
    x = sbq.pop_front();
    check({tag, "_hit"}, 32'(csr_hit), 32'h0);
    check(x.tag, csr_dout, x.exp);
  endtask

  task automatic wr(input logic [11:0] a,
                    input logic [1:0]  op,
                    input logic [31:0] d);
    @(negedge clk_core);
    csr_addr  = a;
    csr_write = op;
    csr_din   = d;
    @(negedge clk_core);
    csr_write = 2'b00;
  endtask

  task automatic pulse(input logic [NE-1:0] v);
    @(negedge clk_core);
    hpm_events = v;
    @(negedge clk_core);
    hpm_events = '0;
  endtask

  initial begin
    reset_n     = 1'b0;
    csr_addr    = '0;
    csr_write   = 2'b00;
    csr_din     = '0;
    inst_retire = 1'b0;
    hpm_events  = '0;
    repeat (2) @(negedge clk_core);
    reset_n = 1'b1;
    repeat (10) @(negedge clk_core);
    rd("mcycle_10", 12'hB00, 32'd10);
    rd("minstret_0", 12'hB02, 32'd0);
    rd("hpm3_0", 12'hB03, 32'd0);

    wr(12'h323, 2'b01, 32'd5);
    rd("evt3_sel5", 12'h323, 32'd5);
    repeat (7) begin
      pulse(16'h0020);
      @(negedge clk_core);
    end
    rd("hpm3_7", 12'hB03, 32'd7);

    wr(12'h323, 2'b01, 32'd0);
    repeat (2) pulse(16'h0020);
    rd("hpm3_sel0", 12'hB03, 32'd7);
    wr(12'h323, 2'b01, 32'd16);
    rd("evt3_sel16", 12'h323, 32'd16);
    repeat (2) pulse(16'h0020);
    rd("hpm3_selne", 12'hB03, 32'd7);

    wr(12'hB83, 2'b01, 32'hFFFF_FFFF);
    rd("hpm3_hi_trunc", 12'hB83, 32'h0000_00FF);
    wr(12'hB03, 2'b01, 32'hFFFF_FFFE);
    wr(12'h323, 2'b01, 32'h4000_0005);
    pulse(16'h0020);
    rd("hpm3_allones", 12'hB03, 32'hFFFF_FFFF);
    pulse(16'h0020);
    check("irq_before", 32'(hpm_irq), 32'd0);
    rd("hpm3_wrap_lo", 12'hB03, 32'd0);
    rd("hpm3_wrap_hi", 12'hB83, 32'd0);
    rd("evt3_of", 12'h323, 32'hC000_0005);
    @(negedge clk_core);
    check("irq_rise", 32'(hpm_irq), 32'd1);
    wr(12'h323, 2'b11, 32'h8000_0000);
    check("irq_hold", 32'(hpm_irq), 32'd1);
    rd("evt3_ofclr", 12'h323, 32'h4000_0005);
    @(negedge clk_core);
    check("irq_drop", 32'(hpm_irq), 32'd0);

    wr(12'h324, 2'b01, 32'd6);
    @(negedge clk_core);
    csr_addr   = 12'hB04;
    csr_write  = 2'b01;
    csr_din    = 32'h100;
    hpm_events = 16'h0040;
    @(negedge clk_core);
    csr_write  = 2'b00;
    hpm_events = '0;
    rd("wr_beats_inc", 12'hB04, 32'h100);
    rd("wr_beats_inc_hi", 12'hB84, 32'h0);

    wr(12'hB84, 2'b01, 32'hFFFF_FFFF);
    wr(12'hB04, 2'b01, 32'hFFFF_FFFF);
    @(negedge clk_core);
    csr_addr   = 12'h324;
    csr_write  = 2'b01;
    csr_din    = 32'd6;
    hpm_events = 16'h0040;
    @(negedge clk_core);
    csr_write  = 2'b00;
    hpm_events = '0;
    rd("of_beats_clr", 12'h324, 32'h8000_0006);
    rd("hpm4_wrap", 12'hB04, 32'd0);
    rd("hpm4_wrap_hi", 12'hB84, 32'd0);

    wr(12'h320, 2'b01, 32'hFFFF_FFFF);
    rd("inh_all", 12'h320, 32'h0000_007D);
    wr(12'h320, 2'b01, 32'h5);
    rd("inh_5", 12'h320, 32'h5);
    wr(12'hB00, 2'b01, 32'h1234);
    wr(12'hB02, 2'b01, 32'h55);
    @(negedge clk_core);
    inst_retire = 1'b1;
    repeat (20) @(negedge clk_core);
    inst_retire = 1'b0;
    rd("mcycle_frozen", 12'hB00, 32'h1234);
    rd("minstret_frozen", 12'hB02, 32'h55);

    wr(12'hB03, 2'b01, 32'hABCD);
    @(negedge clk_core);
    csr_addr  = 12'hC00;
    csr_write = 2'b01;
    csr_din   = 32'h0;
    #1;
    check("shadow_err", 32'(csr_error), 32'd1);
    check("shadow_hit", 32'(csr_hit), 32'd1);
    @(negedge clk_core);
    csr_write = 2'b00;
    rd("shadow_nowr", 12'hB00, 32'h1234);
    rd("shadow_c03", 12'hC03, 32'hABCD);
    rd("b03_abcd", 12'hB03, 32'hABCD);
    rd_miss("miss_b07", 12'hB07);
    rd_miss("miss_321", 12'h321);

    wr(12'h320, 2'b01, 32'h0);
    inst_retire = 1'b1;
    repeat (5) @(negedge clk_core);
    inst_retire = 1'b0;
    rd("minstret_5", 12'hB02, 32'h5A);

    wr(12'h324, 2'b10, 32'h4000_0000);
    @(negedge clk_core);
    check("irq_hpm4", 32'(hpm_irq), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_irq", 32'(hpm_irq), 32'd0);
    rd("rst_mcycle", 12'hB00, 32'd0);
    rd("rst_evt4", 12'h324, 32'd0);
    rd("rst_inh", 12'h320, 32'd0);
    @(negedge clk_core);
    reset_n = 1'b1;
    @(negedge clk_core);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_hpm.md
# csr_hpm

- Parametrised hardware performance-monitor CSR bank: mcycle, minstret, NUM_COUNTERS programmable mhpmcounters, mcountinhibit, and per-counter sticky overflow flags with a registered overflow interrupt.
- Sits beside the machine-mode CSR file on the memory1 CSR port.
- Same read/write/set/clear encoding as the main CSR file; the CSR file ORs in csr_dout, csr_hit and csr_error.
- Adds programmable event selection, counter inhibit, configurable counter width and overflow interrupts.

## Interface
- NUM_COUNTERS, 4, implemented mhpmcounters, legal range 1..29, indices 3..3+NUM_COUNTERS-1
- COUNTER_WIDTH, 64, width of every counter, legal range 33..64
- NUM_EVENTS, 16, width of event input bus, legal range 2..256
- clk_core  in  1  core clock
- reset_n  in  1  reset, asynchronous assert, active-low
- csr_addr  in  12  CSR address from memory1
- csr_write  in  2  00 none, 01 write, 10 set, 11 clear
- csr_din  in  32  CSR operand
- csr_dout  out  32  read data, combinational; 0 when not hit
- csr_hit  out  1  csr_addr decodes to a register in this block
- csr_error  out  1  write, set or clear to a read-only shadow address
- inst_retire  in  1  one instruction retired this cycle (writeback valid)
- hpm_events  in  NUM_EVENTS  per-cycle event strobes; bit 0 is "no event" and is ignored
- hpm_irq  out  1  registered overflow interrupt

## Operation
- Address map:
  - mcycle B00/B80, minstret B02/B82, mhpmcounterN B00+N/B80+N (low/high halves).
  - mcountinhibit 320; mhpmeventN 320+N.
  - Read-only shadows C00-C1F/C80-C9F mirror B00-B1F/B80-B9F.
  - Unimplemented indices miss (csr_hit=0).
- Write data: wdata = din (01), dout|din (10), dout&~din (11). dout is the current read value of the addressed register.
- Counter writes:
  - A low-half write replaces bits [31:0].
  - A high-half write replaces bits [COUNTER_WIDTH-1:32]; wdata bits above COUNTER_WIDTH-33 are dropped.
  - The other half is unchanged.
  - High-half read zero-extends.
- mcountinhibit:
  - Bit 0 inhibits mcycle; bit 2 inhibits minstret; bits 3..3+NUM_COUNTERS-1 inhibit the hpm counters.
  - Bit 1 and unimplemented bits read 0 and ignore writes.
- mhpmeventN layout:
  - [31] OF, sticky overflow flag.
  - [30] OVFIE, overflow interrupt enable.
  - [7:0] EVSEL; EVSEL >= NUM_EVENTS or 0 counts nothing.
  - Other bits read 0.
- Increment conditions, each counter +1 per cycle at most:
  - mcycle every cycle.
  - minstret when inst_retire.
  - hpmN when hpm_events[EVSEL] is 1.
  - Each condition is gated by its inhibit bit.
- Wrap: all-ones +1 gives 0 and sets OF of that counter in the same edge. mcycle and minstret have no OF.
- Simultaneous events:
  - A CSR write to either half of a counter wins over its increment. The counter takes the written value and the increment is lost.
  - OF set by wrap wins over a CSR write clearing OF in the same cycle; other mhpmevent fields take the written value.
  - A write to mcountinhibit or EVSEL affects counting from the next cycle.
- hpm_irq <= OR over N of (OF_N & OVFIE_N), registered. It stays asserted until software clears OF or OVFIE.
- csr_error = (csr_write != 0) & csr_hit & (csr_addr[11:10] == 2'b11). On a shadow address no state changes.
- Reset: all counters, mcountinhibit, mhpmevent and hpm_irq go to 0. Outputs then read 0.

## Timing
- Read: combinational, same cycle as csr_addr.
- Write: visible on the next cycle's read.
- Increment: counts a strobe sampled at edge k. The new value is readable in cycle k+1.
- Overflow to interrupt:
  - A wrap at edge k sets OF at edge k.
  - hpm_irq rises at edge k+1 (one cycle of latency).
  - Clearing OF at edge j drops hpm_irq at edge j+1.
- Reset: asynchronous, state clears immediately on reset_n low. Any in-flight write is discarded. Counting resumes on the first edge after deassertion.
- There are no stalls or handshakes; csr_write is single-cycle.

## Test plan
- Reset, then idle 10 cycles: read B00 gives 10 (±1 per the defined edge); B02 and B03 give 0. Assert reset_n low mid-run: all reads give 0 immediately.
- Set mhpmevent3 EVSEL=5 and pulse hpm_events[5] on 7 non-consecutive cycles -> B03 gives 7. Set EVSEL=0 or EVSEL=NUM_EVENTS -> count stays 7.
- Write B83=FFFFFFFF and B03=FFFFFFFE with OVFIE=1, then 2 events -> counter gives 0, OF=1, hpm_irq rises one cycle after the wrap. Clear OF via csr_write=11 din=80000000 -> hpm_irq drops next cycle.
- Write B04=0x100 in the same cycle as a selected event -> B04 reads 0x100. Wrap in the same cycle as a write clearing OF -> OF reads 1.
- Set mcountinhibit=0x5 -> mcycle and minstret freeze across 20 cycles with inst_retire high. Bit 1 reads 0 after a write of FFFFFFFF.
- Write C00 -> csr_error=1 and mcycle unchanged. Read C03 equals B03. Read B00+NUM_COUNTERS+3 -> csr_hit=0 and dout=0. With COUNTER_WIDTH=40, write B83=FFFFFFFF -> read gives 000000FF.
